// File: rtl/wb_ram_burst.sv
// Wishbone B4 single-port RAM slave with classic and incrementing-burst
// cycles, optional wait states before the first beat, and an error
// acknowledge for byte addresses beyond the memory capacity.
module wb_ram_burst #(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_SIZE    = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    input  logic                    wb_we_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_cyc_i,
    input  logic [2:0]              wb_cti_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    wb_err_o
);

    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int LSB       = $clog2(BYTES);
    localparam int MEM_DEPTH = MEM_SIZE * 1024 * 8 / DATA_WIDTH;
    localparam int AW        = $clog2(MEM_DEPTH);

    localparam logic [2:0]    WS_LAST   = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);
    localparam logic [AW-1:0] LAST_WORD = AW'(MEM_DEPTH - 1);
    localparam logic [2:0]    CTI_INCR  = 3'b010;

    typedef enum logic [1:0] {IDLE, WAIT, BURST, GAP} state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic                    oor_q, oor_d;
    logic [2:0]              cnt_q, cnt_d;

    logic                    cyc_stb;
    logic [AW-1:0]           in_addr;
    logic                    in_oor;
    logic                    beat;
    logic [AW-1:0]           beat_addr;
    logic                    beat_oor;

    logic                    ack_d, err_d, mem_we, rd_en;
    logic                    rd_valid_q;
    logic [DATA_WIDTH-1:0]   rd_q;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    logic                    unused_lsb;

    // Decode the incoming request: word index and out-of-range flag
    always_comb begin
        cyc_stb    = wb_cyc_i & wb_stb_i;
        in_addr    = wb_adr_i[AW+LSB-1:LSB];
        in_oor     = (wb_adr_i >> (AW + LSB)) != 32'd0;
        unused_lsb = ^(wb_adr_i & 32'(BYTES - 1));
    end

    // State register with latched address, range flag and wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            oor_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            oor_q   <= oor_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; 'beat' marks the edge at which a beat is acknowledged
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        oor_d     = oor_q;
        cnt_d     = cnt_q;
        beat      = 1'b0;
        beat_addr = addr_q;
        beat_oor  = oor_q;
        unique case (state_q)
            IDLE: begin
                if (cyc_stb) begin
                    addr_d = in_addr;
                    oor_d  = in_oor;
                    cnt_d  = '0;
                    if (WAIT_STATES == 0) begin
                        beat      = 1'b1;
                        beat_addr = in_addr;
                        beat_oor  = in_oor;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!cyc_stb)
                    state_d = IDLE;
                else if (cnt_q == WS_LAST)
                    beat = 1'b1;
                else
                    cnt_d = cnt_q + 3'd1;
            end
            BURST: begin
                if (!wb_cyc_i)
                    state_d = IDLE;
                else if (wb_stb_i)
                    beat = 1'b1;
            end
            GAP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Any beat that is not an in-range incrementing beat ends the cycle
        if (beat) begin
            if (beat_oor || wb_cti_i != CTI_INCR) begin
                state_d = GAP;
            end else begin
                state_d = BURST;
                addr_d  = (beat_addr == LAST_WORD) ? '0 : beat_addr + AW'(1);
            end
        end
    end

    // Output decode: ack or err for the current beat, memory write/read enables
    always_comb begin
        ack_d  = beat & ~beat_oor;
        err_d  = beat & beat_oor;
        mem_we = ack_d & wb_we_i & ~rst;
        rd_en  = ack_d & ~wb_we_i;
    end

    // Registered acknowledge, error and read-data-valid flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ack_o   <= 1'b0;
            wb_err_o   <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            wb_ack_o   <= ack_d;
            wb_err_o   <= err_d;
            rd_valid_q <= rd_en;
        end
    end

    // Byte-lane masked write and synchronous read; no reset so it maps to RAM
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (wb_sel_i[i])
                    mem[beat_addr][8*i +: 8] <= wb_dat_i[8*i +: 8];
            end
        end
        rd_q <= mem[beat_addr];
    end

    // The RAM output register has no reset, so read data is qualified by a
    // reset-clearable valid flag to force zero outside read acks.
    always_comb begin
        wb_dat_o = rd_valid_q ? rd_q : '0;
    end

endmodule

// File: tb/tb_wb_ram_burst.sv
// Directed bench for wb_ram_burst: table of classic transactions plus
// hand-written burst, wait-state, gap and reset sequences.
module tb_wb_ram_burst;

    logic        clk;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        stb;
    logic        cyc;
    logic [2:0]  cti;
    logic [31:0] dat0, dat3;
    logic        ack0, err0, ack3, err3;

    int checks = 0;
    int errors = 0;

    wb_ram_burst #(.DATA_WIDTH(32), .MEM_SIZE(64), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel),
        .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_cti_i(cti),
        .wb_dat_o(dat0), .wb_ack_o(ack0), .wb_err_o(err0)
    );

    wb_ram_burst #(.DATA_WIDTH(32), .MEM_SIZE(64), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst), .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel),
        .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_cti_i(cti),
        .wb_dat_o(dat3), .wb_ack_o(ack3), .wb_err_o(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [2:0]  cti;
        logic        ack;
        logic        err;
        logic [31:0] q;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // One classic transaction on dut0, then a check that the following cycle is idle
    task automatic classic(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [2:0] c,
                           output logic ack, output logic err, output logic [31:0] q);
        @(negedge clk);
        we = w; adr = a; dat = d; sel = s; cti = c; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        ack = ack0; err = err0; q = dat0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        chk("classic_after_ack", {30'd0, ack0, err0}, 32'd0);
    endtask

    // Transaction on dut3: reports on which edge after the request its ack arrived
    task automatic run3(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int first, output logic [31:0] q);
        @(negedge clk);
        we = w; adr = a; dat = d; sel = 4'hF; cti = 3'b000; cyc = 1'b1; stb = 1'b1;
        first = 0;
        q = '0;
        for (int e = 1; e <= 8 && first == 0; e++) begin
            @(posedge clk); #1;
            if (ack3) begin
                first = e;
                q = dat3;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        chk("ws_ack_one_cycle", {31'd0, ack3}, 32'd0);
    endtask

    logic        r_ack, r_err;
    logic [31:0] r_q;
    int          first;
    int          seen;

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 3'b000, 1'b1, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0100, 32'h0,         4'hF, 3'b000, 1'b1, 1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0040, 32'hAABB_CCDD, 4'hF, 3'b000, 1'b1, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 32'h0000_0040, 32'h1122_3344, 4'h5, 3'b000, 1'b1, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0040, 32'h0,         4'hF, 3'b000, 1'b1, 1'b0, 32'hAA22_CC44};
        vecs[5]  = '{1'b1, 32'h0000_0200, 32'hCAFE_F00D, 4'hF, 3'b001, 1'b1, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 32'h0000_0200, 32'h9988_7766, 4'h8, 3'b000, 1'b1, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_0200, 32'h0,         4'hF, 3'b000, 1'b1, 1'b0, 32'h99FE_F00D};
        vecs[8]  = '{1'b0, 32'h0001_0000, 32'h0,         4'hF, 3'b000, 1'b0, 1'b1, 32'h0};
        vecs[9]  = '{1'b1, 32'h0001_0100, 32'h5555_5555, 4'hF, 3'b000, 1'b0, 1'b1, 32'h0};
        vecs[10] = '{1'b0, 32'h0000_0100, 32'h0,         4'hF, 3'b000, 1'b1, 1'b0, 32'hDEAD_BEEF};
        vecs[11] = '{1'b0, 32'h0000_0040, 32'h0,         4'hF, 3'b111, 1'b1, 1'b0, 32'hAA22_CC44};

        rst = 1'b0; adr = '0; dat = '0; sel = '0; we = 1'b0; stb = 1'b0; cyc = 1'b0; cti = '0;

        // Asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("reset_ack", {31'd0, ack0}, 32'd0);
        chk("reset_err", {31'd0, err0}, 32'd0);
        chk("reset_dat", dat0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Table of classic transactions
        for (int i = 0; i < 12; i++) begin
            classic(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].cti, r_ack, r_err, r_q);
            chk($sformatf("vec%0d_ack", i), {31'd0, r_ack}, {31'd0, vecs[i].ack});
            chk($sformatf("vec%0d_err", i), {31'd0, r_err}, {31'd0, vecs[i].err});
            chk($sformatf("vec%0d_dat", i), r_q, vecs[i].q);
        end

        // Classic request held across cycles: ack, gap, ack
        @(negedge clk);
        we = 1'b0; adr = 32'h100; cti = 3'b000; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        chk("b2b_first_ack", {31'd0, ack0}, 32'd1);
        @(posedge clk); #1;
        chk("b2b_gap", {31'd0, ack0}, 32'd0);
        @(posedge clk); #1;
        chk("b2b_second_ack", {31'd0, ack0}, 32'd1);
        chk("b2b_second_dat", dat0, 32'hDEAD_BEEF);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;

        // Burst write across the top of memory with a stb pause
        @(negedge clk);
        we = 1'b1; sel = 4'hF; adr = 32'h0000_FFF8; dat = 32'd1; cti = 3'b010; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        chk("bw_beat1_ack", {31'd0, ack0}, 32'd1);
        chk("bw_beat1_dat", dat0, 32'd0);
        adr = 32'h0; dat = 32'd2;
        @(posedge clk); #1;
        chk("bw_beat2_ack", {31'd0, ack0}, 32'd1);
        stb = 1'b0; dat = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        chk("bw_pause_noack", {31'd0, ack0}, 32'd0);
        stb = 1'b1; dat = 32'd3;
        @(posedge clk); #1;
        chk("bw_beat3_ack", {31'd0, ack0}, 32'd1);
        dat = 32'd4; cti = 3'b111;
        @(posedge clk); #1;
        chk("bw_beat4_ack", {31'd0, ack0}, 32'd1);
        we = 1'b0; adr = 32'h100; cti = 3'b000;
        @(posedge clk); #1;
        chk("bw_gap", {31'd0, ack0}, 32'd0);
        @(posedge clk); #1;
        chk("bw_after_gap_ack", {31'd0, ack0}, 32'd1);
        chk("bw_after_gap_dat", dat0, 32'hDEAD_BEEF);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;

        // Burst read back: words MEM_DEPTH-2, MEM_DEPTH-1, 0, 1
        @(negedge clk);
        we = 1'b0; adr = 32'h0000_FFF8; cti = 3'b010; cyc = 1'b1; stb = 1'b1;
        for (int b = 1; b <= 4; b++) begin
            if (b == 4) cti = 3'b111;
            @(posedge clk); #1;
            chk($sformatf("br_beat%0d_ack", b), {31'd0, ack0}, 32'd1);
            chk($sformatf("br_beat%0d_dat", b), dat0, 32'(b));
            adr = 32'h0;
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        chk("br_end", {31'd0, ack0}, 32'd0);

        // Wait states on dut3: ack on the fourth edge after the request
        run3(1'b1, 32'h300, 32'h0BAD_F00D, first, r_q);
        chk("ws_write_latency", 32'(first), 32'd4);
        run3(1'b0, 32'h300, 32'h0, first, r_q);
        chk("ws_read_latency", 32'(first), 32'd4);
        chk("ws_read_dat", r_q, 32'h0BAD_F00D);

        // Request withdrawn during wait states: no ack, then a fresh request is served normally
        @(negedge clk);
        we = 1'b1; adr = 32'h300; dat = 32'h1234_5678; sel = 4'hF; cti = 3'b000; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        stb = 1'b0; we = 1'b0;
        seen = 0;
        for (int e = 0; e < 5; e++) begin
            @(posedge clk); #1;
            if (ack3 || err3) seen++;
        end
        cyc = 1'b0;
        chk("ws_abort_noack", 32'(seen), 32'd0);
        run3(1'b0, 32'h300, 32'h0, first, r_q);
        chk("ws_abort_then_latency", 32'(first), 32'd4);
        chk("ws_abort_mem_kept", r_q, 32'h0BAD_F00D);

        // Reset mid-burst: beat 1 committed, beat 2 discarded
        classic(1'b1, 32'h404, 32'h7777_7777, 4'hF, 3'b000, r_ack, r_err, r_q);
        chk("pre_rst_write_ack", {31'd0, r_ack}, 32'd1);
        @(negedge clk);
        we = 1'b1; adr = 32'h400; dat = 32'h0000_00A1; sel = 4'hF; cti = 3'b010; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        chk("rst_burst_beat1_ack", {31'd0, ack0}, 32'd1);
        dat = 32'h0000_00A2;
        #3 rst = 1'b1;
        #1;
        chk("rst_mid_ack", {31'd0, ack0}, 32'd0);
        chk("rst_mid_err", {31'd0, err0}, 32'd0);
        chk("rst_mid_dat", dat0, 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        classic(1'b0, 32'h400, 32'h0, 4'hF, 3'b000, r_ack, r_err, r_q);
        chk("rst_beat1_kept", r_q, 32'h0000_00A1);
        classic(1'b0, 32'h404, 32'h0, 4'hF, 3'b000, r_ack, r_err, r_q);
        chk("rst_beat2_not_written", r_q, 32'h7777_7777);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_ram_burst.md
WB_RAM_BURST -- requirements
Module: wb_ram_burst

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits (multiple of 8).
REQ-002 SHALL have parameter MEM_SIZE, default 64, capacity in KB; MEM_DEPTH = MEM_SIZE*1024*8/DATA_WIDTH words, AW = $clog2(MEM_DEPTH).
REQ-003 SHALL have parameter WAIT_STATES, default 0, range 0..7, extra cycles before ack of the first beat of a cycle.
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port wb_adr_i  input  32  byte address; word index = wb_adr_i[AW+1:2] (32-bit case, generally log2(DATA_WIDTH/8) low bits dropped).
REQ-007 SHALL have port wb_dat_i  input  DATA_WIDTH  write data.
REQ-008 SHALL have port wb_sel_i  input  DATA_WIDTH/8  byte-lane enables.
REQ-009 SHALL have port wb_we_i  input  1  write enable.
REQ-010 SHALL have ports wb_stb_i and wb_cyc_i  input  1 each  strobe and cycle.
REQ-011 SHALL have port wb_cti_i  input  3  cycle type: 000 classic, 010 incrementing burst, 111 end-of-burst; other codes treated as 000.
REQ-012 SHALL have port wb_dat_o  output  DATA_WIDTH  registered read data.
REQ-013 SHALL have port wb_ack_o  output  1  registered acknowledge.
REQ-014 SHALL have port wb_err_o  output  1  registered error acknowledge.

Function
REQ-015 SHALL use FSM states IDLE, WAIT, BURST, GAP.
REQ-016 IDLE: on cyc&stb, latch word address into internal counter addr_q; WAIT_STATES=0 -> drive ack/err next edge; else -> WAIT.
REQ-017 WAIT SHALL count WAIT_STATES cycles with cyc&stb held, then drive first ack/err; cyc or stb dropping in WAIT -> IDLE, no access.
REQ-018 Out-of-range: byte address bits above word index nonzero -> wb_err_o for one cycle instead of ack, no write, wb_dat_o = 0, -> GAP.
REQ-019 Each acked beat: write commits at the edge raising wb_ack_o, only lanes with wb_sel_i[n]=1 updated; read data in wb_dat_o in same cycle as wb_ack_o.
REQ-020 Classic (cti 000/other): exactly one ack cycle, then GAP.
REQ-021 Burst (cti 010 at first beat): -> BURST; addr_q increments by 1 per ack, wrapping MEM_DEPTH-1 -> 0; one ack per cycle while cyc&stb, no further wait states; data/we/sel sampled per beat, wb_adr_i ignored after first beat.
REQ-022 BURST: stb low with cyc high -> ack low, addr_q held, resume on stb; cyc low -> IDLE.
REQ-023 Beat acked with cti=111 SHALL be the last; -> GAP.
REQ-024 GAP SHALL hold ack/err low for exactly one cycle, -> IDLE, so back-to-back classic cycles are ≥2 cycles apart.
REQ-025 wb_ack_o and wb_err_o SHALL never be high together; wb_dat_o = 0 whenever wb_ack_o low or write beat.
REQ-026 Memory contents SHALL not be initialised or cleared by reset (inferrable as block RAM).

Reset
REQ-027 On rst high, regardless of clk: state IDLE, wb_ack_o=0, wb_err_o=0, wb_dat_o=0, addr_q=0, wait counter=0.
REQ-028 Reset mid-cycle SHALL abort it; beats not yet acked SHALL not write; memory keeps already-committed data.

Verification
REQ-029 Classic write 0xDEADBEEF to 0x100, sel=1111, WAIT_STATES=0 -> ack 1 cycle after stb; read 0x100 -> wb_dat_o=0xDEADBEEF with ack.
REQ-030 Write 0x11223344 to 0x40 sel=0101 over prior 0xAABBCCDD -> read returns 0xAA22CC44.
REQ-031 WAIT_STATES=3, classic read -> ack exactly 4 cycles after stb first high; stb dropped after 2 cycles -> no ack, FSM IDLE.
REQ-032 Burst write 4 beats from word MEM_DEPTH-2, cti 010,010,010,111, data 1..4 -> 4 consecutive acks, words MEM_DEPTH-2, MEM_DEPTH-1, 0, 1 hold 1,2,3,4; then one GAP cycle.
REQ-033 Classic read at address MEM_SIZE*1024 -> wb_err_o 1 cycle, wb_ack_o 0, wb_dat_o 0, memory unchanged.
REQ-034 rst asserted between clk edges in beat 2 of burst write -> ack/err/dat_o 0 immediately; beat 1 retained, beats 2+ not written.
